// File: rtl/if_stage.sv
// Instruction fetch: issues word requests, buffers returns and drives the IF/ID register with decode redirects.
// Latency: with a 1-cycle memory a word requested in cycle N reaches the IF/ID register at the edge ending cycle N+1.
// Backpressure: stall holds IF/ID while the buffer fills; requests stop once buffered plus in-flight words reach BUF_DEPTH.
module if_stage #(
    parameter int                     BUS_WIDTH   = 64,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0]   RESET_PC    = '0,
    parameter int                     BUF_DEPTH   = 2,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   imm_pc,
    input  logic [BUS_WIDTH-1:0]   next_imm_pc,
    output logic                   imem_req,
    output logic [BUS_WIDTH-1:0]   imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [BUS_WIDTH-1:0]   pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid
);

    localparam int                   PTR_W      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W:0]       DEPTH_V    = (PTR_W + 1)'(BUF_DEPTH);
    localparam logic [BUS_WIDTH-1:0] PC_STEP    = BUS_WIDTH'(4);
    localparam logic [BUS_WIDTH-1:0] ALIGN_MASK = ~(BUS_WIDTH'(3));

    typedef struct packed {
        logic [BUS_WIDTH-1:0]   pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] fetch_pc, req_pc;
    logic                 epoch, req_epoch;

    entry_t               fb_mem [BUF_DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [PTR_W:0]       count, occ;
    entry_t               head;

    logic redirect, resp_ok, pop, bypass, push, space, grant;

    // Redirect, response acceptance and buffer steering for this cycle.
    always_comb begin
        redirect = imm_pc & instr_valid & ~stall;
        // A response is kept only if it belongs to the current path and no redirect kills it now.
        resp_ok  = (state_q == S_WAIT) & imem_rvalid & (req_epoch == epoch) & ~redirect;
        pop      = ~stall & ~redirect & (count != '0);
        bypass   = ~stall & ~redirect & (count == '0) & resp_ok;
        push     = resp_ok & ~bypass;
        // The word retiring this cycle is counted only if it lands in the buffer.
        occ      = count + {{PTR_W{1'b0}}, push};
        space    = (occ < DEPTH_V);
        head     = fb_mem[rd_ptr];
    end

    // Request FSM next state and request strobe; memory shares rst_n so no request while in reset.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            S_REQ: begin
                imem_req = rst_n & space & ~redirect;
                if (imem_req && imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    imem_req = rst_n & space & ~redirect;
                    state_d  = (imem_req && imem_gnt) ? S_WAIT : S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign grant     = imem_req & imem_gnt;
    assign imem_addr = fetch_pc;

    // Fetch PC, path epoch and the tag of the single outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            fetch_pc  <= RESET_PC;
            epoch     <= 1'b0;
            req_pc    <= '0;
            req_epoch <= 1'b0;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                fetch_pc <= next_imm_pc & ALIGN_MASK;
                epoch    <= ~epoch;
            end else if (grant) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (grant) begin
                req_pc    <= fetch_pc;
                req_epoch <= epoch;
            end
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Buffer storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) fb_mem[wr_ptr] <= '{pc: req_pc, instr: imem_rdata};
    end

    // IF/ID register: hold on stall, bubble on redirect, else buffer head, then bypass, then bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (!stall) begin
            if (pop) begin
                pc          <= head.pc;
                instr       <= head.instr;
                instr_valid <= 1'b1;
            end else if (bypass) begin
                pc          <= req_pc;
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end else begin
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage with a reactive instruction memory model.
// Memory returns addr[31:0] ^ 32'hDEAD0000; grant delay and response latency are programmable.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_if_stage;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk, rst_n, stall, imm_pc;
    logic [63:0] next_imm_pc, imem_addr, pc;
    logic        imem_req, imem_gnt, imem_rvalid, instr_valid;
    logic [31:0] imem_rdata, instr;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage #(
        .BUS_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(RST_PC), .BUF_DEPTH(2), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .imm_pc(imm_pc), .next_imm_pc(next_imm_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc(pc), .instr(instr), .instr_valid(instr_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return lo ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory model ----------------
    int          gnt_delay = 0;
    int          rv_lat    = 1;
    int          req_wait  = 0;
    int          pend_cnt  = 0;
    bit          pend      = 1'b0;
    logic [63:0] pend_addr = '0;
    bit          seen_req, seen_gnt;
    logic [63:0] seen_addr;

    assign imem_gnt = imem_req && (req_wait >= gnt_delay);

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            seen_req  = imem_req;
            seen_gnt  = imem_gnt;
            seen_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (!rst_n) begin
                pend     = 1'b0;
                req_wait = 0;
            end else begin
                if (seen_req && seen_gnt) begin
                    pend      = 1'b1;
                    pend_addr = seen_addr;
                    pend_cnt  = 0;
                    req_wait  = 0;
                end else if (seen_req) begin
                    req_wait++;
                end else begin
                    req_wait = 0;
                end
                if (pend) begin
                    pend_cnt++;
                    if (pend_cnt >= rv_lat) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(pend_addr);
                        pend        = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic        stall;
        logic        imm;
        logic [63:0] tgt;
        logic        e_valid;
        logic [63:0] e_pc;
        logic        e_req;
        logic [63:0] e_addr;
    } vec_t;

    vec_t vecs[19];

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        stall  = 1'b0;
        imm_pc = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_pc, prev_addr;
        bit          prev_req, prev_gnt, found;
        int          n_valid, n_bubble;

        // One row per cycle from reset release: 1-cycle memory, stall window, redirect, ignored redirect under stall.
        vecs[0]  = '{1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 64'h1000};
        vecs[1]  = '{1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 64'h1004};
        vecs[2]  = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h1000, 1'b1, 64'h1008};
        vecs[3]  = '{1'b1, 1'b0, 64'h0,    1'b1, 64'h1004, 1'b1, 64'h100C};
        vecs[4]  = '{1'b1, 1'b0, 64'h0,    1'b1, 64'h1004, 1'b0, 64'h1010};
        vecs[5]  = '{1'b1, 1'b0, 64'h0,    1'b1, 64'h1004, 1'b0, 64'h1010};
        vecs[6]  = '{1'b1, 1'b0, 64'h0,    1'b1, 64'h1004, 1'b0, 64'h1010};
        vecs[7]  = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h1004, 1'b0, 64'h1010};
        vecs[8]  = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h1008, 1'b1, 64'h1010};
        vecs[9]  = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h100C, 1'b1, 64'h1014};
        vecs[10] = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h1010, 1'b1, 64'h1018};
        vecs[11] = '{1'b0, 1'b1, 64'h2002, 1'b1, 64'h1014, 1'b0, 64'h101C};
        vecs[12] = '{1'b0, 1'b0, 64'h0,    1'b0, 64'h1014, 1'b1, 64'h2000};
        vecs[13] = '{1'b0, 1'b0, 64'h0,    1'b0, 64'h1014, 1'b1, 64'h2004};
        vecs[14] = '{1'b1, 1'b1, 64'h3000, 1'b1, 64'h2000, 1'b1, 64'h2008};
        vecs[15] = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h2000, 1'b0, 64'h200C};
        vecs[16] = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h2004, 1'b1, 64'h200C};
        vecs[17] = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h2008, 1'b1, 64'h2010};
        vecs[18] = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h200C, 1'b1, 64'h2014};

        rst_n       = 1'b0;
        stall       = 1'b0;
        imm_pc      = 1'b0;
        next_imm_pc = '0;

        @(negedge clk);
        chk("rst_pc",    pc, 64'h0);
        chk("rst_instr", 64'(instr), 64'(NOP));
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_req",   64'(imem_req), 64'd0);

        step();
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            if (i > 0) step();
            stall       = vecs[i].stall;
            imm_pc      = vecs[i].imm;
            next_imm_pc = vecs[i].tgt;
            @(negedge clk);
            chk($sformatf("row%0d_valid", i), 64'(instr_valid), 64'(vecs[i].e_valid));
            chk($sformatf("row%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("row%0d_instr", i), 64'(instr),
                64'(vecs[i].e_valid ? mem_word(vecs[i].e_pc) : NOP));
            chk($sformatf("row%0d_req", i), 64'(imem_req), 64'(vecs[i].e_req));
            chk($sformatf("row%0d_addr", i), imem_addr, vecs[i].e_addr);
        end

        // Variable latency: grant after 3 cycles of request, response 5 cycles after grant.
        reset_dut();
        gnt_delay = 3;
        rv_lat    = 5;
        step();
        rst_n     = 1'b1;
        exp_pc    = RST_PC;
        prev_req  = 1'b0;
        prev_gnt  = 1'b0;
        prev_addr = '0;
        n_valid   = 0;
        n_bubble  = 0;
        for (int c = 0; c < 150 && n_valid < 4; c++) begin
            @(negedge clk);
            if (prev_req && !prev_gnt && imem_req) chk("vl_addr_hold", imem_addr, prev_addr);
            if (instr_valid) begin
                chk("vl_pc", pc, exp_pc);
                chk("vl_instr", 64'(instr), 64'(mem_word(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                n_valid++;
            end else if (n_valid > 0) begin
                chk("vl_bubble_instr", 64'(instr), 64'(NOP));
                n_bubble++;
            end
            prev_req  = imem_req;
            prev_gnt  = imem_gnt;
            prev_addr = imem_addr;
        end
        chk("vl_valid_count", 64'(n_valid), 64'd4);
        chk("vl_bubbles_seen", 64'(n_bubble > 0), 64'd1);

        // PC wrap through a redirect to the top word; low target bits are dropped.
        reset_dut();
        gnt_delay = 0;
        rv_lat    = 1;
        step();
        rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
        end
        chk("wrap_warmup", 64'(found), 64'd1);
        step();
        imm_pc      = 1'b1;
        next_imm_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        chk("wrap_redir_taken", 64'(instr_valid), 64'd1);
        step();
        imm_pc = 1'b0;
        @(negedge clk);
        chk("wrap_bubble", 64'(instr_valid), 64'd0);
        chk("wrap_req_top", 64'(imem_req), 64'd1);
        chk("wrap_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        @(negedge clk);
        chk("wrap_req_zero", 64'(imem_req), 64'd1);
        chk("wrap_addr_zero", imem_addr, 64'h0);
        step();
        @(negedge clk);
        chk("wrap_out_top_v", 64'(instr_valid), 64'd1);
        chk("wrap_out_top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_out_top_i", 64'(instr), 64'h2152_FFFC);
        step();
        @(negedge clk);
        chk("wrap_out_zero_v", 64'(instr_valid), 64'd1);
        chk("wrap_out_zero_pc", pc, 64'h0);
        chk("wrap_out_zero_i", 64'(instr), 64'hDEAD_0000);
        rv_lat = 5;

        // Reset asserted while a request is outstanding.
        step();
        @(negedge clk);
        chk("midwait_valid", 64'(instr_valid), 64'd1);
        chk("midwait_req", 64'(imem_req), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc, 64'h0);
        chk("async_rst_instr", 64'(instr), 64'(NOP));
        chk("async_rst_valid", 64'(instr_valid), 64'd0);
        chk("async_rst_req", 64'(imem_req), 64'd0);
        rv_lat = 1;
        step();
        @(negedge clk);
        chk("held_rst_valid", 64'(instr_valid), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_req", 64'(imem_req), 64'd1);
        chk("restart_addr", imem_addr, RST_PC);
        step();
        step();
        @(negedge clk);
        chk("restart_valid", 64'(instr_valid), 64'd1);
        chk("restart_pc", pc, RST_PC);
        chk("restart_instr", 64'(instr), 64'(mem_word(RST_PC)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
